// File: rtl/gate_sweep_ctrl.sv
// Sweeps the four {a,b} vectors into a 2-input gate, samples its output after a
// settle time and checks it against a truth table, reporting errors and the first bad vector.
module gate_sweep_ctrl #(
    parameter logic [3:0] TRUTH      = 4'b0111,
    parameter int         SETTLE_CYC = 2,
    parameter int         NUM_PASSES = 1,
    parameter int         ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_c,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass_ok,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
);

    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] LAST_PASS     = 8'(NUM_PASSES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state, state_nx;
    logic [1:0]       vec, vec_nx;
    logic [7:0]       settle_cnt, settle_nx;
    logic [7:0]       pass_cnt, pass_nx;
    logic             a_nx, b_nx;
    logic             pass_ok_nx;
    logic [ERR_W-1:0] err_nx;
    logic             fail_valid_nx;
    logic [1:0]       fail_vec_nx;
    logic             mismatch;

    assign mismatch = (dut_c != TRUTH[{dut_a, dut_b}]);
    assign busy     = (state == SETTLE) || (state == SAMPLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 2'd0;
            settle_cnt <= 8'd0;
            pass_cnt   <= 8'd0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            pass_ok    <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
        end else begin
            state      <= state_nx;
            vec        <= vec_nx;
            settle_cnt <= settle_nx;
            pass_cnt   <= pass_nx;
            dut_a      <= a_nx;
            dut_b      <= b_nx;
            pass_ok    <= pass_ok_nx;
            err_cnt    <= err_nx;
            fail_valid <= fail_valid_nx;
            fail_vec   <= fail_vec_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        vec_nx        = vec;
        settle_nx     = settle_cnt;
        pass_nx       = pass_cnt;
        a_nx          = dut_a;
        b_nx          = dut_b;
        pass_ok_nx    = pass_ok;
        err_nx        = err_cnt;
        fail_valid_nx = fail_valid;
        fail_vec_nx   = fail_vec;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx      = SETTLE;
                    vec_nx        = 2'd0;
                    a_nx          = 1'b0;
                    b_nx          = 1'b0;
                    settle_nx     = SETTLE_RELOAD;
                    pass_nx       = 8'd0;
                    err_nx        = '0;
                    fail_valid_nx = 1'b0;
                    pass_ok_nx    = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nx   = IDLE;
                    a_nx       = 1'b0;
                    b_nx       = 1'b0;
                    pass_ok_nx = 1'b0;
                end else if (settle_cnt == 8'd0) begin
                    state_nx = SAMPLE;
                end else begin
                    settle_nx = settle_cnt - 8'd1;
                end
            end
            SAMPLE: begin
                // An abort here throws away this vector's compare result.
                if (abort) begin
                    state_nx   = IDLE;
                    a_nx       = 1'b0;
                    b_nx       = 1'b0;
                    pass_ok_nx = 1'b0;
                end else begin
                    if (mismatch) begin
                        if (err_cnt != '1) begin
                            err_nx = err_cnt + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_valid_nx = 1'b1;
                            fail_vec_nx   = {dut_a, dut_b};
                        end
                    end
                    settle_nx = SETTLE_RELOAD;
                    if (vec != 2'd3) begin
                        vec_nx       = vec + 2'd1;
                        {a_nx, b_nx} = vec + 2'd1;
                        state_nx     = SETTLE;
                    end else if (pass_cnt < LAST_PASS) begin
                        pass_nx      = pass_cnt + 8'd1;
                        vec_nx       = 2'd0;
                        {a_nx, b_nx} = 2'b00;
                        state_nx     = SETTLE;
                    end else begin
                        {a_nx, b_nx} = 2'b00;
                        state_nx     = DONE;
                        pass_ok_nx   = (err_nx == '0);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (abort) begin
                    a_nx       = 1'b0;
                    b_nx       = 1'b0;
                    pass_ok_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: two instances (NAND defaults, and AND with fast
// settle, two passes, narrow counter) driven by behavioural gates with random faults.
module tb_gate_sweep_ctrl;

    typedef struct {
        int         done_cyc;
        int         err;
        logic       fvalid;
        logic [1:0] fvec;
        logic       pass_ok;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] dut_c_v, a_v, b_v, busy_v, done_v, pok_v, fvld_v;
    logic [1:0] fvec0, fvec1;
    logic [3:0] err0;
    logic [1:0] err1;
    logic [3:0] tbl [2];

    int   cyc = 0;
    int   acc = 0;
    int   total = 0;
    int   bad = 0;
    logic active [2];
    logic last_pok [2];
    exp_t sbq0 [$];
    exp_t sbq1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dut_c_v[0] = tbl[0][{a_v[0], b_v[0]}];
    assign dut_c_v[1] = tbl[1][{a_v[1], b_v[1]}];

    gate_sweep_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_c(dut_c_v[0]),
        .dut_a(a_v[0]), .dut_b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass_ok(pok_v[0]), .err_cnt(err0), .fail_valid(fvld_v[0]), .fail_vec(fvec0)
    );

    gate_sweep_ctrl #(.TRUTH(4'b1000), .SETTLE_CYC(1), .NUM_PASSES(2), .ERR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_c(dut_c_v[1]),
        .dut_a(a_v[1]), .dut_b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass_ok(pok_v[1]), .err_cnt(err1), .fail_valid(fvld_v[1]), .fail_vec(fvec1)
    );

    function automatic int settleOf(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int passesOf(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int errMax(int i);
        return (i == 0) ? 15 : 3;
    endfunction

    function automatic logic [3:0] truthOf(int i);
        return (i == 0) ? 4'b0111 : 4'b1000;
    endfunction

    function automatic int runLen(int i);
        return 4 * passesOf(i) * (settleOf(i) + 1);
    endfunction

    function automatic int errOf(int i);
        return (i == 0) ? int'(err0) : int'(err1);
    endfunction

    function automatic int fvecOf(int i);
        return (i == 0) ? int'(fvec0) : int'(fvec1);
    endfunction

    // Outcome after ncmp completed compares, walking vectors 0..3 repeatedly.
    function automatic exp_t modelRun(int i, logic [3:0] gate, int ncmp);
        exp_t       r;
        logic [3:0] truth;
        int         cnt;
        truth     = truthOf(i);
        cnt       = 0;
        r.fvalid  = 1'b0;
        r.fvec    = 2'd0;
        for (int j = 0; j < ncmp; j++) begin
            if (gate[j % 4] != truth[j % 4]) begin
                cnt++;
                if (!r.fvalid) begin
                    r.fvalid = 1'b1;
                    r.fvec   = 2'(j % 4);
                end
            end
        end
        r.err      = (cnt > errMax(i)) ? errMax(i) : cnt;
        r.pass_ok  = (cnt == 0);
        r.done_cyc = 0;
        return r;
    endfunction

    function automatic logic [3:0] gateFor(int mode, logic [3:0] truth);
        case (mode)
            0:       return truth;
            1:       return 4'b0000;
            2:       return 4'b1111;
            3:       return ~truth;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic checkOutput(input string name, input int inst, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s inst%0d: got %0d expected %0d (cycle %0d)", name, inst, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearRuns();
        sbq0.delete();
        sbq1.delete();
        active[0] = 1'b0;
        active[1] = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag, input int i, input exp_t e);
        checkOutput({tag, "_busy"}, i, busy_v[i], 0);
        checkOutput({tag, "_ab"}, i, {a_v[i], b_v[i]}, 0);
        checkOutput({tag, "_pass_ok"}, i, pok_v[i], 0);
        checkOutput({tag, "_err"}, i, errOf(i), e.err);
        checkOutput({tag, "_fvalid"}, i, fvld_v[i], e.fvalid);
        if (e.fvalid) checkOutput({tag, "_fvec"}, i, fvecOf(i), e.fvec);
    endtask

    // action 0: full run with a stray start at cycle k; 1: abort at k; 2: reset at k.
    task automatic applyStimulus(input int action, input int k, input int m0, input int m1);
        exp_t e;
        int   kk;
        tbl[0] = gateFor(m0, truthOf(0));
        tbl[1] = gateFor(m1, truthOf(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = cyc;
        for (int i = 0; i < 2; i++) begin
            e = modelRun(i, tbl[i], 4 * passesOf(i));
            e.done_cyc = acc + runLen(i);
            if (i == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
            active[i] = 1'b1;
        end
        for (int j = 0; j < 40 && (active[0] || active[1]); j++) begin
            kk = cyc - acc;
            if (kk == k) begin
                if (action == 0) start = 1'b1;
                if (action == 1) abort = 1'b1;
                if (action == 2) rst_n = 1'b0;
            end
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (kk == k && action == 1) begin
                clearRuns();
                for (int i = 0; i < 2; i++)
                    checkIdleOutputs("abort", i, modelRun(i, tbl[i], k / (settleOf(i) + 1)));
            end
            if (kk == k && action == 2) begin
                rst_n = 1'b1;
                clearRuns();
                for (int i = 0; i < 2; i++)
                    checkIdleOutputs("reset", i, modelRun(i, tbl[i], 0));
            end
        end
        if (active[0] || active[1]) begin
            checkOutput("run_timeout", 0, 1, 0);
            clearRuns();
        end
        tick();
        tick();
        if (action == 0) begin
            for (int i = 0; i < 2; i++) checkOutput("pass_ok_hold", i, pok_v[i], last_pok[i]);
        end
    endtask

    // Monitor: checks every cycle of a run and pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            logic have;
            int   k;
            if (done_v[i]) begin
                have = 1'b0;
                if (i == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1'b1; end
                if (i == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1'b1; end
                if (!have) begin
                    checkOutput("done_unexpected", i, 1, 0);
                end else begin
                    checkOutput("done_cycle", i, cyc, e.done_cyc);
                    checkOutput("done_err", i, errOf(i), e.err);
                    checkOutput("done_pass_ok", i, pok_v[i], e.pass_ok);
                    checkOutput("done_fvalid", i, fvld_v[i], e.fvalid);
                    if (e.fvalid) checkOutput("done_fvec", i, fvecOf(i), e.fvec);
                    checkOutput("done_ab", i, {a_v[i], b_v[i]}, 0);
                    checkOutput("done_busy", i, busy_v[i], 0);
                    last_pok[i] = e.pass_ok;
                end
                active[i] = 1'b0;
            end else if (active[i]) begin
                k = cyc - acc;
                if (k < runLen(i)) begin
                    checkOutput("run_busy", i, busy_v[i], 1);
                    checkOutput("run_vector", i, {a_v[i], b_v[i]}, (k / (settleOf(i) + 1)) % 4);
                end else begin
                    checkOutput("done_missing", i, 0, 1);
                    if (i == 0) sbq0.delete();
                    else        sbq1.delete();
                    active[i] = 1'b0;
                end
            end else begin
                checkOutput("idle_busy", i, busy_v[i], 0);
            end
        end
    end

    initial begin
        exp_t zero;
        int   act, kk;
        tbl[0] = 4'b0111;
        tbl[1] = 4'b1000;
        active[0] = 1'b0;
        active[1] = 1'b0;
        last_pok[0] = 1'b0;
        last_pok[1] = 1'b0;
        zero = modelRun(0, 4'b0111, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkIdleOutputs("por", i, zero);
            checkOutput("por_done", i, done_v[i], 0);
        end

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) checkOutput("abort_beats_start", i, busy_v[i], 0);

        applyStimulus(0, 5, 0, 0);
        applyStimulus(0, 11, 1, 1);
        applyStimulus(0, 1, 3, 3);
        applyStimulus(1, 7, 1, 1);
        applyStimulus(0, 3, 1, 2);
        applyStimulus(2, 1, 4, 4);
        applyStimulus(0, 2, 2, 3);

        for (int n = 0; n < 24; n++) begin
            act = $urandom_range(0, 2);
            kk  = (act == 0) ? $urandom_range(1, 11) : $urandom_range(0, 11);
            applyStimulus(act, kk, $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
